// File: rtl/rng_pool_if.sv
// Bus bundle between the entropy conditioner and its consumer.
interface rng_pool_if;
  localparam int unsigned WORD_W = 32;

  logic              rng_in;
  logic              re;
  logic              clear_fault;
  logic [WORD_W-1:0] so;
  logic              valid;
  logic              fault;

  modport master (output rng_in, re, clear_fault, input so, valid, fault);
  modport slave  (input rng_in, re, clear_fault, output so, valid, fault);
endinterface

// File: rtl/rng_pool.sv
// Entropy conditioner: synchronize raw noise, von Neumann debias, pack into
// double-buffered 32-bit words, and trip a sticky fault on a stuck source.
module rng_pool #(
  parameter int unsigned SAMPLE_DIV   = 16,
  parameter int unsigned REPEAT_LIMIT = 64
) (
  input  logic       clk,
  input  logic       rst,
  rng_pool_if.slave  bus
);
  localparam int unsigned PRE_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned REP_W  = $clog2(REPEAT_LIMIT + 1);
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned WORD_W = 32;

  typedef enum logic {ST_FIRST, ST_SECOND} pair_t;

  logic              sync1, sync2;
  logic [PRE_W-1:0]  pre_cnt;
  logic              tick_c;
  pair_t             pair_st;
  logic              b0;
  logic              prev;
  logic [REP_W-1:0]  rep_cnt;
  logic              same_c;
  logic              hit_c;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] so_r;
  logic [CNT_W-1:0]  bit_cnt;
  logic              acc_full;
  logic              valid_r;
  logic              fault_r;
  logic              emit_c;
  logic              last_c;
  logic [WORD_W-1:0] acc_next_c;

  assign tick_c     = (pre_cnt == PRE_W'(SAMPLE_DIV - 1));
  assign same_c     = (sync2 == prev);
  // Only the transition into the limit trips; a saturated counter does not
  // re-fire, so clear_fault can take effect on a still-stuck source.
  assign hit_c      = tick_c && same_c && (rep_cnt == REP_W'(REPEAT_LIMIT - 1));
  assign emit_c     = tick_c && (pair_st == ST_SECOND) && (sync2 != b0)
                      && !fault_r && !bus.clear_fault;
  assign last_c     = (bit_cnt == CNT_W'(WORD_W - 1));
  assign acc_next_c = {acc[WORD_W-2:0], b0};

  assign bus.so    = so_r;
  assign bus.valid = valid_r;
  assign bus.fault = fault_r;

  // Two-flop synchronizer for the asynchronous noise input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bus.rng_in;
      sync2 <= sync1;
    end
  end

  // Sample-rate prescaler; tick on the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick_c) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Repetition-count health test and sticky fault (set beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev    <= 1'b0;
      rep_cnt <= '0;
      fault_r <= 1'b0;
    end else begin
      if (tick_c) begin
        prev <= sync2;
      end
      if (bus.clear_fault) begin
        rep_cnt <= '0;
      end else if (tick_c) begin
        if (!same_c) begin
          rep_cnt <= REP_W'(1);
        end else if (rep_cnt != REP_W'(REPEAT_LIMIT)) begin
          rep_cnt <= rep_cnt + REP_W'(1);
        end
      end
      if (hit_c) begin
        fault_r <= 1'b1;
      end else if (bus.clear_fault) begin
        fault_r <= 1'b0;
      end
    end
  end

  // Pair FSM, accumulator, output word and read handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_st  <= ST_FIRST;
      b0       <= 1'b0;
      acc      <= '0;
      bit_cnt  <= '0;
      acc_full <= 1'b0;
      so_r     <= '0;
      valid_r  <= 1'b0;
    end else if (fault_r) begin
      pair_st  <= ST_FIRST;
      acc      <= '0;
      bit_cnt  <= '0;
      acc_full <= 1'b0;
      so_r     <= '0;
      valid_r  <= 1'b0;
    end else begin
      if (bus.clear_fault) begin
        pair_st <= ST_FIRST;
      end else if (tick_c) begin
        if (pair_st == ST_FIRST) begin
          b0      <= sync2;
          pair_st <= ST_SECOND;
        end else begin
          pair_st <= ST_FIRST;
        end
      end
      if (bus.re && valid_r) begin
        if (acc_full) begin
          so_r     <= acc;
          acc_full <= 1'b0;
          bit_cnt  <= '0;
        end else begin
          valid_r <= 1'b0;
        end
      end
      // A completed word goes straight out if the slot is free or being read.
      if (emit_c && !acc_full) begin
        if (last_c) begin
          bit_cnt <= '0;
          if (!valid_r || bus.re) begin
            so_r    <= acc_next_c;
            valid_r <= 1'b1;
          end else begin
            acc      <= acc_next_c;
            acc_full <= 1'b1;
          end
        end else begin
          acc     <= acc_next_c;
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_rng_pool.sv
// Self-checking bench for rng_pool: directed vectors plus a randomized run
// against a behavioural model.
module tb_rng_pool;
  localparam int unsigned LIM = 64;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rng_pool_if b1 ();
  rng_pool_if b16 ();

  rng_pool #(.SAMPLE_DIV(1), .REPEAT_LIMIT(LIM)) dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );
  rng_pool #(.SAMPLE_DIV(16), .REPEAT_LIMIT(LIM)) dut16 (
    .clk(clk), .rst(rst), .bus(b16.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0]  pat;
    int          lat;
    logic [31:0] word;
  } vec_t;

  vec_t tbl [6];

  // Reference model state (SAMPLE_DIV=1: every clock is a sample).
  bit          m_sy0, m_sy1, m_prev, m_pend, m_first, m_full, m_valid, m_fault;
  int          m_run;
  bit          m_bits [$];
  logic [31:0] m_held, m_so;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic rin, input logic r, input logic cf);
    b1.rng_in      = rin;
    b1.re          = r;
    b1.clear_fault = cf;
    @(posedge clk);
    #1;
    b1.re          = 1'b0;
    b1.clear_fault = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    b1.rng_in = 1'b0; b1.re = 1'b0; b1.clear_fault = 1'b0;
    b16.rng_in = 1'b0; b16.re = 1'b0; b16.clear_fault = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic model_reset();
    m_sy0 = 0; m_sy1 = 0; m_prev = 0; m_pend = 0; m_first = 0;
    m_full = 0; m_valid = 0; m_fault = 0; m_run = 0;
    m_held = '0; m_so = '0;
    m_bits.delete();
  endtask

  task automatic model_step(input bit rin, input bit r);
    bit smp, old_valid, old_full, hit;
    logic [31:0] w;
    smp = m_sy1; m_sy1 = m_sy0; m_sy0 = rin;
    hit = 0;
    if (smp == m_prev) begin
      if (m_run < LIM) begin
        m_run++;
        hit = (m_run == LIM);
      end
    end else begin
      m_run = 1;
    end
    m_prev = smp;
    if (m_fault) begin
      m_so = '0; m_valid = 0; m_full = 0; m_pend = 0;
      m_bits.delete();
    end else begin
      old_valid = m_valid;
      old_full  = m_full;
      if (r && old_valid) begin
        if (old_full) begin
          m_so = m_held; m_full = 0;
        end else begin
          m_valid = 0;
        end
      end
      if (!m_pend) begin
        m_first = smp; m_pend = 1;
      end else begin
        m_pend = 0;
        if (smp != m_first && !old_full) begin
          m_bits.push_back(m_first);
          if (m_bits.size() == 32) begin
            w = '0;
            for (int i = 0; i < 32; i++) w[31-i] = m_bits[i];
            m_bits.delete();
            if (!old_valid || r) begin
              m_so = w; m_valid = 1;
            end else begin
              m_held = w; m_full = 1;
            end
          end
        end
      end
    end
    if (hit) m_fault = 1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) begin
      cyc(w[i], 1'b0, 1'b0);
      cyc(~w[i], 1'b0, 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w1, w2, w3;
    logic [3:0]  p;
    bit          rin, r;

    tbl[0] = '{4'b1010, 66,  32'h0000_0000};  // 0,1,0,1
    tbl[1] = '{4'b0101, 66,  32'hFFFF_FFFF};  // 1,0,1,0
    tbl[2] = '{4'b1001, 66,  32'hAAAA_AAAA};  // 1,0,0,1
    tbl[3] = '{4'b0110, 66,  32'h5555_5555};  // 0,1,1,0
    tbl[4] = '{4'b1011, 130, 32'h0000_0000};  // 1,1,0,1
    tbl[5] = '{4'b0100, 130, 32'hFFFF_FFFF};  // 0,0,1,0

    rst = 1'b1;
    b1.rng_in = 1'b0; b1.re = 1'b0; b1.clear_fault = 1'b0;
    b16.rng_in = 1'b0; b16.re = 1'b0; b16.clear_fault = 1'b0;
    #1;
    chk("reset_so",      b1.so,     32'h0);
    chk("reset_valid",   b1.valid,  32'h0);
    chk("reset_fault",   b1.fault,  32'h0);
    chk("reset16_valid", b16.valid, 32'h0);

    // Pattern table: word value and exact latency.
    for (int k = 0; k < 6; k++) begin
      do_reset();
      p = tbl[k].pat;
      for (int e = 1; e <= tbl[k].lat; e++) begin
        cyc(p[(e-1) % 4], 1'b0, 1'b0);
        if (e == tbl[k].lat - 1) chk($sformatf("tbl%0d_early_valid", k), b1.valid, 32'h0);
      end
      chk($sformatf("tbl%0d_valid", k), b1.valid, 32'h1);
      chk($sformatf("tbl%0d_so", k),    b1.so,    tbl[k].word);
      chk($sformatf("tbl%0d_fault", k), b1.fault, 32'h0);
    end

    // Backpressure: three words, no reads.
    w1 = 32'h1234_5678; w2 = 32'hCAFE_F00D; w3 = 32'h0F0F_0F0F;
    do_reset();
    send_word(w1);
    send_word(w2);
    send_word(w3);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("bp_word1",     b1.so,    w1);
    chk("bp_valid1",    b1.valid, 32'h1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("bp_word2",     b1.so,    w2);
    chk("bp_valid2",    b1.valid, 32'h1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("bp_hold2",     b1.so,    w2);
    cyc(1'b0, 1'b1, 1'b0);
    chk("bp_drain",     b1.valid, 32'h0);
    chk("bp_so_kept",   b1.so,    w2);
    cyc(1'b0, 1'b1, 1'b0);
    chk("bp_idle_re_v", b1.valid, 32'h0);
    chk("bp_idle_re_s", b1.so,    w2);

    // Stuck source, then clear with source still stuck.
    do_reset();
    for (int e = 1; e <= 66; e++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (e == 65) chk("stuck_early", b1.fault, 32'h0);
    end
    chk("stuck_fault", b1.fault, 32'h1);
    chk("stuck_valid", b1.valid, 32'h0);
    chk("stuck_so",    b1.so,    32'h0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("clear_fault", b1.fault, 32'h0);
    for (int k = 1; k <= 64; k++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (k == 63) chk("refault_early", b1.fault, 32'h0);
    end
    chk("refault", b1.fault, 32'h1);

    // Recovery: alternating stream, clear, new word 64 ticks later.
    for (int i = 0; i < 4; i++) cyc(1'(i % 2), 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("recover_clear", b1.fault, 32'h0);
    for (int k = 1; k <= 64; k++) begin
      cyc(1'((k + 4) % 2), 1'b0, 1'b0);
      if (k == 63) chk("recover_early", b1.valid, 32'h0);
    end
    chk("recover_valid", b1.valid, 32'h1);
    chk("recover_so",    b1.so,    32'hFFFF_FFFF);
    chk("recover_fault", b1.fault, 32'h0);

    // Limit hit and clear in the same cycle: set wins.
    do_reset();
    for (int e = 1; e <= 65; e++) cyc(1'b1, 1'b0, 1'b0);
    chk("setwin_pre", b1.fault, 32'h0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("setwin", b1.fault, 32'h1);

    // Asynchronous reset mid-word.
    do_reset();
    for (int i = 0; i < 106; i++) cyc(1'((i + 1) % 2), 1'b0, 1'b0);
    chk("mid_pre_valid", b1.valid, 32'h1);
    chk("mid_pre_so",    b1.so,    32'hFFFF_FFFF);
    rst = 1'b1;
    #2;
    chk("mid_rst_so",    b1.so,    32'h0);
    chk("mid_rst_valid", b1.valid, 32'h0);
    chk("mid_rst_fault", b1.fault, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int e = 1; e <= 66; e++) begin
      cyc(1'(e % 2), 1'b0, 1'b0);
      if (e == 65) chk("mid_post_early", b1.valid, 32'h0);
    end
    chk("mid_post_valid", b1.valid, 32'h1);
    chk("mid_post_so",    b1.so,    32'hFFFF_FFFF);

    // SAMPLE_DIV=16: one sample every 16 clocks.
    do_reset();
    for (int j = 0; j < 1024; j++) begin
      b16.rng_in = 1'((j / 16) % 2);
      @(posedge clk);
      #1;
      if (j == 1022) chk("div16_early", b16.valid, 32'h0);
    end
    chk("div16_valid", b16.valid, 32'h1);
    chk("div16_so",    b16.so,    32'h0);
    chk("div16_fault", b16.fault, 32'h0);

    // Randomized stream and reads against the model.
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      rin = 1'($urandom % 2);
      r   = ($urandom % 6) == 0;
      model_step(rin, r);
      cyc(rin, r, 1'b0);
      chk("rand_so",    b1.so,    m_so);
      chk("rand_valid", b1.valid, 32'(m_valid));
      chk("rand_fault", b1.fault, 32'(m_fault));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
